adc_scan_ctrl: RTL

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_scan_ctrl_if.sv | 13 +
 rtl/adc_clk_div.sv | 21 ++
 rtl/adc_scan_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM states, default timing and channel helper for the ADC0809 scanner
package adc_pkg;
  localparam int DEF_CLK_DIV = 25;
  localparam int DEF_START_W = 5;
  localparam int DEF_OE_W = 4;
  localparam int DEF_EOC_TIMEOUT = 4000;
  localparam int ADDR_W = 3;
  typedef enum logic [2:0] {IDLE, SETUP, STRT, WAIT_LO, WAIT_HI, READ, NEXT} state_t;
  // first set bit of m at or above from, wrapping; bits above NUM_CH are zero so mod-8 wrap is exact
  function automatic logic [ADDR_W-1:0] pick(input logic [7:0] m, input logic [ADDR_W-1:0] from);
    logic [ADDR_W-1:0] r;
    logic f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [ADDR_W-1:0] c;
      c = from + ADDR_W'(i);
      if (!f && m[c]) begin
        r = c;
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: ADC0809 pin bundle between scan controller (master) and converter (slave)
interface adc_scan_ctrl_if;
  import adc_pkg::*;
  logic ad_clk;
  logic ale;
  logic start;
  logic [ADDR_W-1:0] addr;
  logic OE;
  logic EOC;
  logic [7:0] D;
  modport master (output ad_clk, ale, start, addr, OE, input EOC, D);
  modport slave (input ad_clk, ale, start, addr, OE, output EOC, D);
endinterface

// File: rtl/adc_clk_div.sv
// adc_clk_div: free-running ADC conversion clock, toggles every CLK_DIV sys_clk cycles
module adc_clk_div import adc_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic ad_clk
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ad_clk <= 1'b0;
    end else if (cnt == W'(CLK_DIV - 1)) begin
      cnt <= '0;
      ad_clk <= ~ad_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: round-robin ADC0809 channel scanner with EOC timeout recovery
module adc_scan_ctrl import adc_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int START_W = DEF_START_W,
  parameter int OE_W = DEF_OE_W,
  parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  input  logic [NUM_CH-1:0] ch_mask,
  adc_scan_ctrl_if.master adc,
  output logic [7:0] sample_data,
  output logic [ADDR_W-1:0] sample_ch,
  output logic sample_valid,
  output logic timeout_err,
  output logic busy
);
  localparam int CW = $clog2(EOC_TIMEOUT + START_W + OE_W + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] eoc_s;
  logic eoc, expired, waiting, cap, to;
  logic [ADDR_W-1:0] sel;
  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (.sys_clk(sys_clk), .rst_n(rst_n), .ad_clk(adc.ad_clk));
  assign eoc = eoc_s[1];
  assign expired = cnt == CW'(EOC_TIMEOUT - 1);
  assign waiting = state == WAIT_LO || state == WAIT_HI;
  assign to = waiting && state_n == NEXT;
  assign cap = state == READ && state_n == NEXT;
  assign sel = pick(8'(ch_mask), state == IDLE ? '0 : adc.addr + ADDR_W'(1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = en && |ch_mask ? SETUP : IDLE;
      SETUP:   state_n = STRT;
      STRT:    state_n = cnt == CW'(START_W - 1) ? WAIT_LO : STRT;
      WAIT_LO: state_n = !eoc ? WAIT_HI : expired ? NEXT : WAIT_LO;
      WAIT_HI: state_n = eoc ? READ : expired ? NEXT : WAIT_HI;
      READ:    state_n = cnt == CW'(OE_W - 1) ? NEXT : READ;
      NEXT:    state_n = en && |ch_mask ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // strobes are registered from the next state so they line up with the state they describe
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      eoc_s <= '0;
      adc.ale <= 1'b0;
      adc.start <= 1'b0;
      adc.OE <= 1'b0;
      adc.addr <= '0;
      busy <= 1'b0;
      sample_valid <= 1'b0;
      timeout_err <= 1'b0;
      sample_data <= '0;
      sample_ch <= '0;
    end else begin
      eoc_s <= {eoc_s[0], adc.EOC};
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      adc.ale <= state_n == STRT;
      adc.start <= state_n == STRT;
      adc.OE <= state_n == READ;
      busy <= state_n != IDLE;
      sample_valid <= cap;
      timeout_err <= to;
      if (state_n == SETUP) adc.addr <= sel;
      if (cap) begin
        sample_data <= adc.D;
        sample_ch <= adc.addr;
      end
    end
endmodule
